// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state and
// transaction-owner encodings, plus the kseg0/kseg1 segment bounds used by
// the physical address fold.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  // Top nibble range of the unmapped kseg0/kseg1 windows.
  localparam logic [3:0] KSEG_LO = 4'h8;
  localparam logic [3:0] KSEG_HI = 4'hB;

  // True when the top address nibble lies inside kseg0/kseg1.
  function automatic logic in_kseg01(input logic [3:0] seg);
    return (seg >= KSEG_LO) && (seg <= KSEG_HI);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory bus.
// master: the arbiter's view (drives bus request and completions).
// slave : the environment's view (CPU requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction-fetch requester
  logic              inst_req;
  logic [AW-1:0]     inst_addr;
  logic              inst_done;
  logic [DW-1:0]     inst_rdata;
  logic              inst_err;
  // Data-access requester
  logic              data_req;
  logic              data_wr;
  logic [DW/8-1:0]   data_wstrb;
  logic [AW-1:0]     data_addr;
  logic [DW-1:0]     data_wdata;
  logic              data_done;
  logic [DW-1:0]     data_rdata;
  logic              data_err;
  // Shared memory bus
  logic              mem_req;
  logic              mem_wr;
  logic [DW/8-1:0]   mem_wstrb;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_done, inst_rdata, inst_err,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_done, data_rdata, data_err,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_done, inst_rdata, inst_err,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_done, data_rdata, data_err,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/kseg_addr_map.sv
// Combinational virtual-to-physical fold: addresses in kseg0/kseg1
// (top nibble 0x8..0xB) lose their top three bits; all others pass through.
module kseg_addr_map
  import mem_bus_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr_i,
  output logic [AW-1:0] addr_o
);

  // Strip the segment bits for the unmapped kernel windows.
  always_comb begin
    addr_o = addr_i;
    if (in_kseg01(addr_i[AW-1 -: 4])) begin
      addr_o = {3'b000, addr_i[AW-4:0]};
    end else begin
      addr_o = addr_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data
// access, one transaction outstanding at a time. Every access is bounded
// by TIMEOUT cycles in REQ+RESP (0 disables), ending in an error completion.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// when undefined, DATA has fixed priority over INST.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);

  localparam int            SW     = DW / 8;
  localparam int            CW     = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam bit            TO_EN  = (TIMEOUT != 0);

  // Registered state and outputs
  state_e          state_q;
  owner_e          owner_q;
  logic [CW-1:0]   cnt_q;
  logic            mem_req_q;
  logic            mem_wr_q;
  logic [SW-1:0]   mem_wstrb_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            inst_done_q;
  logic            inst_err_q;
  logic [DW-1:0]   inst_rdata_q;
  logic            data_done_q;
  logic            data_err_q;
  logic [DW-1:0]   data_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e          last_q;
`endif

  // Combinational helpers
  logic            inst_act_s;
  logic            data_act_s;
  logic            any_act_s;
  logic            pick_data_s;
  logic [AW-1:0]   win_addr_s;
  logic            win_wr_s;
  logic [SW-1:0]   win_wstrb_s;
  logic [DW-1:0]   win_wdata_s;
  logic [AW-1:0]   phys_addr_s;
  logic [CW-1:0]   cnt_d;
  logic            to_hit_s;
  logic            cpl_s;
  logic            cpl_err_s;
  logic [DW-1:0]   cpl_rdata_s;

  // Pick the winner among unmasked requests and mux its command fields.
  always_comb begin
    // A requester whose done is high this cycle is masked to avoid double issue.
    inst_act_s  = bus.inst_req & ~inst_done_q;
    data_act_s  = bus.data_req & ~data_done_q;
    any_act_s   = inst_act_s | data_act_s;
    pick_data_s = data_act_s;
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_act_s && data_act_s) begin
      pick_data_s = (last_q == OWN_INST);
    end else begin
      pick_data_s = data_act_s;
    end
`endif
    if (pick_data_s) begin
      win_addr_s  = bus.data_addr;
      win_wr_s    = bus.data_wr;
      win_wstrb_s = bus.data_wstrb;
      win_wdata_s = bus.data_wdata;
    end else begin
      win_addr_s  = bus.inst_addr;
      win_wr_s    = 1'b0;
      win_wstrb_s = {SW{1'b0}};
      win_wdata_s = {DW{1'b0}};
    end
  end

  kseg_addr_map #(.AW(AW)) u_kseg_addr_map (
    .addr_i (win_addr_s),
    .addr_o (phys_addr_s)
  );

  // Decide whether the current transaction completes this cycle and how.
  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    to_hit_s    = TO_EN && (cnt_d == TO_VAL);
    cpl_s       = 1'b0;
    cpl_err_s   = 1'b0;
    cpl_rdata_s = {DW{1'b0}};
    case (state_q)
      REQ: begin
        // Timeout takes precedence over a grant arriving in the same cycle.
        if (to_hit_s) begin
          cpl_s     = 1'b1;
          cpl_err_s = 1'b1;
        end else begin
          cpl_s     = 1'b0;
        end
      end
      RESP: begin
        // A genuine response in the last allowed cycle still wins.
        if (bus.mem_rvalid) begin
          cpl_s       = 1'b1;
          cpl_rdata_s = bus.mem_rdata;
        end else if (to_hit_s) begin
          cpl_s     = 1'b1;
          cpl_err_s = 1'b1;
        end else begin
          cpl_s     = 1'b0;
        end
      end
      default: begin
        cpl_s = 1'b0;
      end
    endcase
  end

  // Request/grant/response FSM with registered bus command and completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      cnt_q        <= {CW{1'b0}};
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= {SW{1'b0}};
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      inst_done_q  <= 1'b0;
      inst_err_q   <= 1'b0;
      inst_rdata_q <= {DW{1'b0}};
      data_done_q  <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= {DW{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= OWN_INST;
`endif
    end else begin
      // Completion flags are single-cycle pulses.
      inst_done_q <= 1'b0;
      inst_err_q  <= 1'b0;
      data_done_q <= 1'b0;
      data_err_q  <= 1'b0;
      if (cpl_s) begin
        if (owner_q == OWN_DATA) begin
          data_done_q  <= 1'b1;
          data_err_q   <= cpl_err_s;
          data_rdata_q <= cpl_rdata_s;
        end else begin
          inst_done_q  <= 1'b1;
          inst_err_q   <= cpl_err_s;
          inst_rdata_q <= cpl_rdata_s;
        end
      end

      case (state_q)
        IDLE: begin
          if (any_act_s) begin
            owner_q     <= pick_data_s ? OWN_DATA : OWN_INST;
            mem_wr_q    <= win_wr_s;
            mem_wstrb_q <= win_wstrb_s;
            mem_addr_q  <= phys_addr_s;
            mem_wdata_q <= win_wdata_s;
            mem_req_q   <= 1'b1;
            cnt_q       <= {CW{1'b0}};
            state_q     <= REQ;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= pick_data_s ? OWN_DATA : OWN_INST;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          cnt_q <= cnt_d;
          if (to_hit_s) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
          end else begin
            state_q <= REQ;
          end
        end
        RESP: begin
          cnt_q <= cnt_d;
          if (cpl_s) begin
            state_q <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.inst_done  = inst_done_q;
  assign bus.inst_err   = inst_err_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_done  = data_done_q;
  assign bus.data_err   = data_err_q;
  assign bus.data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model that
// predicts winners, bus commands, completion cycles and results from
// arrival cycles and grant/response delays.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Requester side of the model
  bit          i_pend, d_pend, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_strb;
  // Transaction in flight
  bit          act, act_data, exp_err, exp_wr;
  int          e_cyc, gd, rd, done_cyc;
  logic [31:0] exp_addr, exp_wdata, act_rdata;
  logic [3:0]  exp_strb;
  bit          last_data;
  int          late_cyc = -1;
  // Stimulus knobs
  int          p_inst, p_data;
  bit          noise_en, rereq_inst, rereq_data, fix_resp;
  int          fix_gd, fix_rd;
  logic [31:0] fix_rdata;
  // Observations
  bit          obs_idone, obs_ddone;
  logic [31:0] seen_addr;
  int          req_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] fold(input logic [31:0] a);
    logic [3:0] seg;
    seg = a[31:28];
    if (seg >= 4'h8 && seg <= 4'hB) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  // Record a newly granted transaction and predict its completion.
  task automatic plan_tx(input bit is_data);
    int r;
    act = 1'b1; act_data = is_data; e_cyc = cyc + 1; last_data = is_data;
    if (is_data) begin
      exp_addr = fold(d_addr); exp_wr = d_wr; exp_strb = d_strb; exp_wdata = d_wdata;
    end else begin
      exp_addr = fold(i_addr); exp_wr = 1'b0; exp_strb = 4'h0; exp_wdata = 32'h0;
    end
    if (fix_resp) begin
      gd = fix_gd; rd = fix_rd; act_rdata = fix_rdata;
    end else begin
      gd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 3, T + 2)) : int'($urandom_range(0, 3));
      rd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 4, T + 6)) : int'($urandom_range(0, 3));
      act_rdata = $urandom;
    end
    if (gd >= T - 1) begin
      done_cyc = e_cyc + T; exp_err = 1'b1;
    end else begin
      r = e_cyc + gd + 1 + rd;
      if (r <= e_cyc + T - 1) begin
        done_cyc = r + 1; exp_err = 1'b0;
      end else begin
        done_cyc = e_cyc + T; exp_err = 1'b1; late_cyc = r;
      end
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic step();
    bit exp_req, idn, ddn, elig_i, elig_d, pick_d, win_req, win_resp, scr_i, scr_d;
    @(negedge clk);
    cyc++;
    exp_req = act && (cyc >= e_cyc) && (cyc <= e_cyc + ((gd < T - 1) ? gd : T - 1));
    chk("mem_req", bus.mem_req, exp_req);
    if (bus.mem_req) begin
      seen_addr = bus.mem_addr;
      req_cycles++;
    end
    if (exp_req) begin
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_wr", bus.mem_wr, exp_wr);
      if (act_data) begin
        chk("mem_wstrb", bus.mem_wstrb, exp_strb);
        chk("mem_wdata", bus.mem_wdata, exp_wdata);
      end
    end
    idn = act && !act_data && (cyc == done_cyc);
    ddn = act && act_data && (cyc == done_cyc);
    obs_idone = bus.inst_done;
    obs_ddone = bus.data_done;
    chk("inst_done", bus.inst_done, idn);
    chk("data_done", bus.data_done, ddn);
    if (idn) begin
      chk("inst_rdata", bus.inst_rdata, exp_err ? 32'h0 : act_rdata);
      chk("inst_err", bus.inst_err, exp_err);
      i_pend = 1'b0; act = 1'b0;
    end
    if (ddn) begin
      chk("data_rdata", bus.data_rdata, exp_err ? 32'h0 : act_rdata);
      chk("data_err", bus.data_err, exp_err);
      d_pend = 1'b0; act = 1'b0;
    end
    // Requesters raise new transactions (possibly right in their done cycle).
    if (!i_pend && (idn ? rereq_inst : ($urandom_range(0, 99) < p_inst))) begin
      i_pend = 1'b1; i_addr = $urandom;
    end
    if (!d_pend && (ddn ? rereq_data : ($urandom_range(0, 99) < p_data))) begin
      d_pend = 1'b1; d_addr = $urandom; d_wdata = $urandom;
      d_wr = 1'($urandom_range(0, 1)); d_strb = 4'($urandom_range(1, 15));
    end
    // Arbitration rule applied to requests visible this cycle.
    if (!act) begin
      elig_i = i_pend && !idn;
      elig_d = d_pend && !ddn;
      if (elig_i || elig_d) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = (elig_i && elig_d) ? !last_data : elig_d;
`else
        pick_d = elig_d;
`endif
        plan_tx(pick_d);
      end
    end
    // Requester inputs; once granted, the owner's fields are scrambled.
    scr_i = act && !act_data && (cyc >= e_cyc);
    scr_d = act && act_data && (cyc >= e_cyc);
    bus.inst_req   = i_pend;
    bus.inst_addr  = scr_i ? $urandom : i_addr;
    bus.data_req   = d_pend;
    bus.data_addr  = scr_d ? $urandom : d_addr;
    bus.data_wdata = scr_d ? $urandom : d_wdata;
    bus.data_wr    = scr_d ? 1'($urandom_range(0, 1)) : d_wr;
    bus.data_wstrb = scr_d ? 4'($urandom_range(0, 15)) : d_strb;
    // Memory responder following the planned delays.
    win_req  = act && (cyc >= e_cyc) && (cyc <= e_cyc + gd);
    win_resp = act && (gd < T - 1) && (cyc > e_cyc + gd) && (cyc <= e_cyc + gd + 1 + rd);
    bus.mem_gnt = win_req ? (cyc == e_cyc + gd) : (noise_en && ($urandom_range(0, 3) == 0));
    if (win_resp) begin
      bus.mem_rvalid = (cyc == e_cyc + gd + 1 + rd);
      bus.mem_rdata  = bus.mem_rvalid ? act_rdata : $urandom;
    end else begin
      bus.mem_rvalid = (cyc == late_cyc) || (noise_en && ($urandom_range(0, 3) == 0));
      bus.mem_rdata  = $urandom;
    end
  endtask

  task automatic wait_done(input bit want_data, input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      step();
      if (want_data ? obs_ddone : obs_idone) begin
        at = cyc;
        break;
      end
    end
    chk("done_within_bound", (at >= 0), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, at, at2;
    bus.inst_req = 1'b0; bus.inst_addr = 32'h0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_wstrb = 4'h0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    p_inst = 0; p_data = 0; noise_en = 1'b0; rereq_inst = 1'b0; rereq_data = 1'b0;
    fix_resp = 1'b1; last_data = 1'b0; act = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_inst_done", bus.inst_done, 1'b0);
    chk("rst_data_done", bus.data_done, 1'b0);
    chk("rst_inst_err", bus.inst_err, 1'b0);
    chk("rst_data_err", bus.data_err, 1'b0);
    chk("rst_inst_rdata", bus.inst_rdata, 32'h0);
    chk("rst_data_rdata", bus.data_rdata, 32'h0);
    rst = 1'b0;

    // Single fetch through kseg1 with minimum latency.
    fix_gd = 0; fix_rd = 0; fix_rdata = 32'h3C08_0001;
    i_pend = 1'b1; i_addr = 32'hBFC0_0000;
    step(); t0 = cyc;
    wait_done(1'b0, 20, at);
    chk("fetch_latency", at - t0, 3);
    chk("fetch_addr", seen_addr, 32'h1FC0_0000);
    chk("fetch_rdata", bus.inst_rdata, 32'h3C08_0001);
    chk("fetch_err", bus.inst_err, 1'b0);

    // Simultaneous requests: data write first, then fetch.
    fix_rdata = 32'h1111_2222;
    i_pend = 1'b1; i_addr = 32'h9FC0_0010;
    d_pend = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_1000; d_strb = 4'hF; d_wdata = 32'hDEAD_BEEF;
    step(); step();
    chk("simul_first_wr", bus.mem_wr, 1'b1);
    chk("simul_first_addr", bus.mem_addr, 32'h0000_1000);
    wait_done(1'b1, 20, at);
    wait_done(1'b0, 20, at2);
    chk("simul_order", (at2 > at), 1'b1);

    // Grant stall of ten cycles, then normal completion.
    fix_gd = 10; fix_rd = 1; fix_rdata = 32'hCAFE_F00D; req_cycles = 0;
    d_pend = 1'b1; d_wr = 1'b0; d_addr = 32'hA000_0040; d_strb = 4'h3; d_wdata = 32'h0;
    step();
    wait_done(1'b1, 30, at);
    chk("stall_req_cycles", req_cycles, 11);
    chk("stall_addr", seen_addr, 32'h0000_0040);
    chk("stall_rdata", bus.data_rdata, 32'hCAFE_F00D);

    // Timeout: response arrives far too late and must be dropped.
    fix_gd = 0; fix_rd = 30;
    d_pend = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_0100;
    step(); t0 = cyc;
    wait_done(1'b1, 40, at);
    chk("timeout_latency", at - t0, T + 1);
    chk("timeout_err", bus.data_err, 1'b1);
    chk("timeout_rdata", bus.data_rdata, 32'h0);
    repeat (40) step();

    // Back-to-back: fetch requester keeps req high through done.
    fix_gd = 0; fix_rd = 0; fix_rdata = 32'h0BAD_CAFE; rereq_inst = 1'b1;
    i_pend = 1'b1; i_addr = 32'h0040_0000;
    step();
    wait_done(1'b0, 20, at);
    rereq_inst = 1'b0;
    chk("b2b_req_in_done", bus.mem_req, 1'b0);
    step();
    chk("b2b_req_next", bus.mem_req, 1'b0);
    step();
    chk("b2b_req_after", bus.mem_req, 1'b1);
    wait_done(1'b0, 20, at);

    // Reset in the middle of RESP.
    fix_gd = 0; fix_rd = 20;
    i_pend = 1'b1; i_addr = 32'h1234_5678;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", bus.mem_req, 1'b0);
    chk("rst_mid_inst_done", bus.inst_done, 1'b0);
    chk("rst_mid_data_done", bus.data_done, 1'b0);
    chk("rst_mid_inst_rdata", bus.inst_rdata, 32'h0);
    chk("rst_mid_data_rdata", bus.data_rdata, 32'h0);
    act = 1'b0; i_pend = 1'b0; d_pend = 1'b0; last_data = 1'b0; late_cyc = -1;
    step(); step();
    rst = 1'b0;
    fix_rd = 0; fix_rdata = 32'h2400_0001;
    i_pend = 1'b1; i_addr = 32'hBFC0_0004;
    step(); t0 = cyc;
    wait_done(1'b0, 20, at);
    chk("post_rst_latency", at - t0, 3);
    chk("post_rst_rdata", bus.inst_rdata, 32'h2400_0001);

    // Randomized traffic with bus noise, stalls and timeouts.
    fix_resp = 1'b0; noise_en = 1'b1; p_inst = 30; p_data = 30;
    for (int n = 0; n < 3000; n++) begin
      rereq_inst = 1'($urandom_range(0, 1));
      rereq_data = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
